// File: rtl/mxu_operand_loader.sv
// rtl/mxu_operand_loader.sv - operand row loader and holding bank for the temporal matrix unit
//
// Purpose: accepts DIM rows of A, then B, then C over a valid/ready stream,
// latches alpha/beta on beat 0, checks tile framing with in_last, then issues
// a one-cycle start and holds every operand until the MXU reports out_valid.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   upstream row handshake (in_ready = state is LOAD)
//   in_data             one row, column j at [j*BIT_WIDTH +: BIT_WIDTH]
//   in_last             final beat marker, required exactly on beat 3*DIM-1
//   in_alpha, in_beta   scalars, sampled on beat 0
//   flush               synchronous abort back to LOAD, clears err
//   mxu_out_valid       MXU result-valid level, observed only in RUN
//   A, B, C             packed [row][col][bit] operand tiles
//   alpha, beta         scalars to the MXU
//   start               one-cycle MXU start pulse
//   busy                high in START or RUN
//   tile_done           one-cycle pulse when the MXU result is valid
//   err                 sticky framing error
module mxu_operand_loader #(
   parameter int DIM       = 16,
   parameter int BIT_WIDTH = 4,
   parameter int CNT_W     = $clog2(3*DIM)+1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DIM*BIT_WIDTH-1:0]       in_data,
   input  logic                           in_last,
   input  logic [BIT_WIDTH-1:0]           in_alpha,
   input  logic [BIT_WIDTH-1:0]           in_beta,
   input  logic                           flush,
   input  logic                           mxu_out_valid,
   output logic [DIM*DIM*BIT_WIDTH-1:0]   A,
   output logic [DIM*DIM*BIT_WIDTH-1:0]   B,
   output logic [DIM*DIM*BIT_WIDTH-1:0]   C,
   output logic [BIT_WIDTH-1:0]           alpha,
   output logic [BIT_WIDTH-1:0]           beta,
   output logic                           start,
   output logic                           busy,
   output logic                           tile_done,
   output logic                           err
);

   localparam int ROW_W  = DIM*BIT_WIDTH;
   localparam int TILE_W = DIM*ROW_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(3*DIM-1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     beat_q, beat_d;
   logic                 err_q, err_d;
   logic [TILE_W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
   logic [BIT_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
   logic                 final_beat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_LOAD;
         beat_q  <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         alpha_q <= '0;
         beta_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         alpha_q <= alpha_d;
         beta_q  <= beta_d;
      end
   end

   assign final_beat = (beat_q == LAST_BEAT);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      err_d   = err_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      alpha_d = alpha_q;
      beta_d  = beta_q;

      if (flush) begin
         // flush wins over everything, including a beat offered this cycle
         state_d = S_LOAD;
         beat_d  = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  // beat index selects one row across the three tiles
                  for (int r = 0; r < DIM; r++) begin
                     if (beat_q == CNT_W'(r))
                        a_d[r*ROW_W +: ROW_W] = in_data;
                     if (beat_q == CNT_W'(DIM + r))
                        b_d[r*ROW_W +: ROW_W] = in_data;
                     if (beat_q == CNT_W'(2*DIM + r))
                        c_d[r*ROW_W +: ROW_W] = in_data;
                  end
                  if (beat_q == '0) begin
                     alpha_d = in_alpha;
                     beta_d  = in_beta;
                  end
                  // in_last must coincide with the final beat; otherwise
                  // drop the tile and restart framing from beat 0
                  if (in_last != final_beat) begin
                     err_d  = 1'b1;
                     beat_d = '0;
                  end else if (final_beat) begin
                     beat_d  = '0;
                     state_d = S_START;
                  end else begin
                     beat_d = beat_q + CNT_W'(1);
                  end
               end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
               if (mxu_out_valid)
                  state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q == S_START) || (state_q == S_RUN);
   assign start     = (state_q == S_START) && !flush;
   assign tile_done = (state_q == S_RUN) && mxu_out_valid && !flush;
   assign err       = err_q;
   assign A         = a_q;
   assign B         = b_q;
   assign C         = c_q;
   assign alpha     = alpha_q;
   assign beta      = beta_q;

endmodule

// File: tb/tb_mxu_operand_loader.sv
// tb/tb_mxu_operand_loader.sv - scoreboard bench for mxu_operand_loader at DIM=2, BIT_WIDTH=4
module tb_mxu_operand_loader;

   localparam int DIM = 2;
   localparam int BW  = 4;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [DIM*BW-1:0]      in_data = '0;
   logic                   in_last = 1'b0;
   logic [BW-1:0]          in_alpha = '0;
   logic [BW-1:0]          in_beta = '0;
   logic                   flush = 1'b0;
   logic                   mxu_out_valid = 1'b0;
   logic [DIM*DIM*BW-1:0]  A, B, C;
   logic [BW-1:0]          alpha, beta;
   logic                   start, busy, tile_done, err;

   mxu_operand_loader #(.DIM(DIM), .BIT_WIDTH(BW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_alpha(in_alpha), .in_beta(in_beta),
      .flush(flush), .mxu_out_valid(mxu_out_valid),
      .A(A), .B(B), .C(C), .alpha(alpha), .beta(beta),
      .start(start), .busy(busy), .tile_done(tile_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [3:0]  al;
      logic [3:0]  be;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_start = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Monitor: every start must match the oldest queued tile and last one cycle.
   always @(negedge clk) begin
      exp_t e;
      if (start) begin
         chk("start_single_cycle", prev_start, 1'b0);
         chk("start_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tile_A", A, e.a);
            chk("tile_B", B, e.b);
            chk("tile_C", C, e.c);
            chk("tile_alpha", alpha, e.al);
            chk("tile_beta", beta, e.be);
         end
      end
      prev_start = start;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_beat(input logic [7:0] d, input logic last, input logic [3:0] al, input logic [3:0] be);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_alpha = al;
      in_beta  = be;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) chk("ready_timeout", 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Well-formed tile; leaves the bench at the first RUN cycle.
   task automatic good_tile(input logic [47:0] rows, input logic [3:0] al, input logic [3:0] be,
                            input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
      exp_q.push_back({ea, eb, ec, al, be});
      for (int b = 0; b < 6; b++)
         do_beat(rows[b*8 +: 8], b == 5, al, be);
      chk("start_after_last", start, 1'b1);
      chk("ready_in_start", in_ready, 1'b0);
      chk("busy_in_start", busy, 1'b1);
      chk("done_not_in_start", tile_done, 1'b0);
      step();
      chk("start_dropped", start, 1'b0);
      chk("busy_in_run", busy, 1'b1);
   endtask

   task automatic finish_run();
      mxu_out_valid = 1'b1;
      #1;
      chk("tile_done_pulse", tile_done, 1'b1);
      step();
      mxu_out_valid = 1'b0;
      chk("ready_after_done", in_ready, 1'b1);
      chk("busy_after_done", busy, 1'b0);
      chk("done_cleared", tile_done, 1'b0);
   endtask

   initial begin
      step();
      step();
      // reset state
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_start", start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tile_done", tile_done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_A", A, 16'h0);
      chk("rst_B", B, 16'h0);
      chk("rst_C", C, 16'h0);
      chk("rst_alpha", alpha, 4'h0);
      chk("rst_beta", beta, 4'h0);
      reset_n = 1'b1;
      step();

      // basic load: A {1,2},{3,4}  B {5,6},{7,0}  C {1,1},{2,2}
      good_tile(48'h2211_0765_4321, 4'h1, 4'h0, 16'h4321, 16'h0765, 16'h2211);
      chk("A10_is_3", A[8 +: 4], 4'h3);
      chk("B01_is_6", B[4 +: 4], 4'h6);
      chk("C11_is_2", C[12 +: 4], 4'h2);

      // hold: upstream keeps pushing junk while in RUN
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         step();
         chk("hold_ready", in_ready, 1'b0);
         chk("hold_A", A, 16'h4321);
         chk("hold_B", B, 16'h0765);
         chk("hold_C", C, 16'h2211);
         chk("hold_no_done", tile_done, 1'b0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_run();

      // early last on beat 2
      do_beat(8'hEE, 1'b0, 4'h9, 4'h9);
      do_beat(8'hEE, 1'b0, 4'h9, 4'h9);
      do_beat(8'hEE, 1'b1, 4'h9, 4'h9);
      chk("early_err", err, 1'b1);
      chk("early_no_start", start, 1'b0);
      chk("early_ready", in_ready, 1'b1);
      good_tile(48'hBC9A_7856_3412, 4'h7, 4'hF, 16'h3412, 16'h7856, 16'hBC9A);
      chk("early_err_sticky", err, 1'b1);
      finish_run();

      // idle flush clears err
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_clears_err", err, 1'b0);

      // missing last on beat 5
      for (int b = 0; b < 6; b++)
         do_beat(8'hDD, 1'b0, 4'h2, 4'h2);
      chk("missing_err", err, 1'b1);
      chk("missing_no_start", start, 1'b0);
      chk("missing_ready", in_ready, 1'b1);
      good_tile(48'h4433_2211_F00F, 4'h3, 4'h5, 16'hF00F, 16'h2211, 16'h4433);
      finish_run();

      // stale mxu_out_valid held high throughout
      mxu_out_valid = 1'b1;
      good_tile(48'h2211_0765_4321, 4'h1, 4'h0, 16'h4321, 16'h0765, 16'h2211);
      chk("stale_done_first_run", tile_done, 1'b1);
      step();
      chk("stale_ready", in_ready, 1'b1);
      chk("stale_done_not_in_load", tile_done, 1'b0);
      mxu_out_valid = 1'b0;

      // flush on beat 3 (err is still set from the missing-last case)
      do_beat(8'hCC, 1'b0, 4'h6, 4'h6);
      do_beat(8'hCC, 1'b0, 4'h6, 4'h6);
      do_beat(8'hCC, 1'b0, 4'h6, 4'h6);
      in_valid = 1'b1;
      in_data  = 8'hCC;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_err_cleared", err, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      good_tile(48'hBC9A_7856_3412, 4'h7, 4'hF, 16'h3412, 16'h7856, 16'hBC9A);
      chk("post_flush_err", err, 1'b0);

      // asynchronous reset mid-RUN
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      chk("arst_start", start, 1'b0);
      chk("arst_err", err, 1'b0);
      chk("arst_A", A, 16'h0);
      chk("arst_B", B, 16'h0);
      chk("arst_C", C, 16'h0);
      chk("arst_alpha", alpha, 4'h0);
      chk("arst_beta", beta, 4'h0);
      #3;
      reset_n = 1'b1;
      step();
      step();
      chk("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, required finished");
      $fatal(1);
   end

endmodule
